brick_sort_ctrl: RTL and testbench

BRICK_SORT_CTRL -- requirements
Module: brick_sort_ctrl

---
 rtl/brick_sort_ctrl.sv | 154 +++++++++++++++
 tb/tb_brick_sort_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_sort_ctrl.sv
// brick_sort_ctrl: loads a frame of N serial elements, launches the parallel sort
// core, waits for its result with a sticky timeout, and unloads the result serially.
module brick_sort_ctrl #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   core_x,
  output logic                                       core_x_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   core_y,
  input  logic                                       core_y_valid,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       err
);

  localparam int                N          = 2**LOG_INPUT_NUM;
  localparam int                IDX_W      = LOG_INPUT_NUM;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N-1);
  localparam int                TCNT_W     = 16;
  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [TCNT_W-1:0]            tcnt;
  logic [N-1:0][DATA_WIDTH-1:0] ibuf;
  logic [N-1:0][DATA_WIDTH-1:0] obuf;

  logic                         in_fire;
  logic                         out_fire;
  logic [IDX_W-1:0]             idx_inc;
  logic [TCNT_W-1:0]            tcnt_inc;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign idx_inc  = idx + IDX_W'(1);
  assign tcnt_inc = tcnt + TCNT_W'(1);

  // The input buffer is presented to the core at all times; it only changes while loading.
  assign core_x = ibuf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      tcnt         <= '0;
      err          <= 1'b0;
      in_ready     <= 1'b0;
      core_x_valid <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      // NOTE: the buffers are cleared on reset so core_x never exposes a stale or aborted frame.
      ibuf         <= '0;
      obuf         <= '0;
    end else begin
      // NOTE: every register here uses <= so all branches see the same pre-edge values.
      core_x_valid <= 1'b0;

      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            ibuf[0] <= in_data;
            idx     <= IDX_W'(1);
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (in_fire) begin
            ibuf[idx] <= in_data;
            idx       <= idx_inc;
            if (idx == IDX_LAST) begin
              in_ready     <= 1'b0;
              core_x_valid <= 1'b1;
              state        <= S_LAUNCH;
            end
          end
        end

        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // A result arriving on the same cycle as the timeout still wins.
          if (core_y_valid) begin
            obuf      <= core_y;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= core_y[DATA_WIDTH-1:0];
            out_last  <= (IDX_LAST == '0);
            state     <= S_UNLOAD;
          end else if (tcnt_inc == TCNT_LIMIT) begin
            err      <= 1'b1;
            tcnt     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        S_UNLOAD: begin
          if (out_fire) begin
            if (idx == IDX_LAST) begin
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              idx      <= idx_inc;
              out_data <= obuf[idx_inc];
              out_last <= (idx_inc == IDX_LAST);
            end
          end
        end

        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          idx       <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brick_sort_ctrl.sv
// tb_brick_sort_ctrl: randomized frames through a bench sort-core model; expected
// serial outputs come from sorting the stimulus frame and are checked by a monitor.
module tb_brick_sort_ctrl;

  localparam int LOG_N = 4;
  localparam int N     = 2**LOG_N;
  localparam int DW    = 32;
  localparam int TMO   = 8;

  typedef logic [N-1:0][DW-1:0] frame_t;
  typedef enum int {CORE_DELAY3, CORE_ALWAYS, CORE_NEVER} core_mode_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [DW*N-1:0] core_x;
  logic            core_x_valid;
  logic [DW*N-1:0] core_y;
  logic            core_y_valid;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            err;

  brick_sort_ctrl #(
    .LOG_INPUT_NUM(LOG_N),
    .DATA_WIDTH   (DW),
    .TIMEOUT      (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_x      (core_x),
    .core_x_valid(core_x_valid),
    .core_y      (core_y),
    .core_y_valid(core_y_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors       = 0;
  int          checks       = 0;
  int          cyc          = 0;
  int          last_launch  = -1000;
  int          respond_at   = -1000;
  int          out_hs_count = 0;
  int          stall_req    = 0;
  bit          ordy_random  = 1'b0;
  core_mode_t  core_mode    = CORE_DELAY3;
  frame_t      sorted_y     = '0;
  frame_t      exp_frames[$];
  logic [DW:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void sort_frame(input frame_t f, output frame_t s);
    logic [DW-1:0] t;
    s = f;
    for (int a = 0; a < N-1; a++)
      for (int b = 0; b < N-1-a; b++)
        if (s[b] > s[b+1]) begin
          t = s[b]; s[b] = s[b+1]; s[b+1] = t;
        end
  endfunction

  task automatic rand_frame(output frame_t f, input int maxv);
    for (int i = 0; i < N; i++)
      f[i] = (maxv == 0) ? DW'($urandom) : DW'($urandom_range(0, maxv));
  endtask

  // Sort-core model: snapshot the operand on launch, answer according to core_mode.
  initial begin : core_sampler
    frame_t cx;
    frame_t ef;
    forever begin
      @(negedge clk);
      if (!rst && core_x_valid) begin
        cx          = core_x;
        last_launch = cyc;
        respond_at  = cyc + 3;
        sort_frame(cx, sorted_y);
        if (exp_frames.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL core_launch: unexpected core_x_valid at cycle %0d with no complete frame loaded", cyc);
        end else begin
          ef = exp_frames.pop_front();
          for (int i = 0; i < N; i++) check($sformatf("core_x_elem%0d", i), 64'(cx[i]), 64'(ef[i]));
        end
      end
    end
  end

  initial begin : core_driver
    core_y_valid = 1'b0;
    core_y       = '0;
    forever begin
      @(posedge clk);
      #1;
      case (core_mode)
        CORE_ALWAYS: begin
          core_y_valid = 1'b1;
          core_y       = sorted_y;
        end
        CORE_DELAY3: begin
          core_y_valid = (cyc == respond_at);
          if (cyc == respond_at) core_y = sorted_y;
        end
        default: core_y_valid = 1'b0;
      endcase
    end
  end

  initial begin : ordy_driver
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0) begin
        out_ready = 1'b0;
        stall_req--;
      end else begin
        out_ready = ordy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks protocol timing.
  initial begin : monitor
    logic [DW:0]   e;
    logic [DW-1:0] stall_data;
    bit            stall_last;
    bit            prev_stall   = 1'b0;
    bit            prev_last_hs = 1'b0;
    bit            prev_ov      = 1'b0;
    bit            prev_err     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
        prev_ov      = 1'b0;
        prev_err     = 1'b0;
        continue;
      end
      if (prev_last_hs) begin
        check("out_valid_after_last", 64'(out_valid), 64'(0));
        check("busy_after_last", 64'(busy), 64'(0));
        check("in_ready_after_last", 64'(in_ready), 64'(1));
      end
      if (prev_stall) begin
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_out_data", 64'(out_data), 64'(stall_data));
        check("stall_out_last", 64'(out_last), 64'(stall_last));
      end
      if (out_valid && !prev_ov)
        check("capture_latency", 64'(cyc - last_launch), 64'((core_mode == CORE_ALWAYS) ? 2 : 4));
      if (err && !prev_err)
        check("timeout_latency", 64'(cyc - last_launch), 64'((core_mode == CORE_NEVER) ? TMO : -1));
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got data %0h last %0b with nothing expected (cycle %0d)", out_data, out_last, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e[DW-1:0]));
          check("out_last", 64'(out_last), 64'(e[DW]));
        end
        out_hs_count++;
        prev_last_hs = out_last;
      end else if (out_valid) begin
        prev_stall = 1'b1;
        stall_data = out_data;
        stall_last = out_last;
      end
      prev_ov  = out_valid;
      prev_err = err;
    end
  end

  // Entered and left at posedge+1. gap: 0 continuous, 1 toggling, 2 random.
  task automatic send_frame(input frame_t vals, input int gap, input int nbeats, input bit expect_out);
    int     i      = 0;
    int     budget = 0;
    bit     vld    = 1'b0;
    bit     acc;
    frame_t srt;
    while (i < nbeats && budget < 400) begin
      case (gap)
        0:       vld = 1'b1;
        1:       vld = ~vld;
        default: vld = 1'($urandom_range(0, 1));
      endcase
      in_valid = vld;
      in_data  = vld ? vals[i] : DW'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      budget++;
    end
    in_valid = 1'b0;
    if (i < nbeats) begin
      checks++;
      errors++;
      $display("FAIL load_budget: accepted %0d beats, required %0d", i, nbeats);
    end
    if (nbeats == N) begin
      exp_frames.push_back(vals);
      if (expect_out) begin
        sort_frame(vals, srt);
        for (int k = 0; k < N; k++) exp_q.push_back({(k == N-1), srt[k]});
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((exp_q.size() != 0 || busy) && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_budget: %0d outputs still pending, busy %0b", exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_core_x_valid"}, 64'(core_x_valid), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_last"}, 64'(out_last), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_core_x_zero"}, 64'(|core_x), 64'(0));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    frame_t v;
    int     base;
    int     b;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("por_release_in_ready", 64'(in_ready), 64'(1));
    check("por_release_busy", 64'(busy), 64'(0));

    // Descending 0xF..0x0, continuous valid, sorted result three cycles after launch.
    for (int i = 0; i < N; i++) v[i] = DW'(N-1-i);
    send_frame(v, 0, N, 1'b1);
    wait_idle(200);

    // in_valid toggling every cycle.
    rand_frame(v, 0);
    send_frame(v, 1, N, 1'b1);
    wait_idle(200);

    // out_ready held low for five cycles mid-unload.
    base = out_hs_count;
    rand_frame(v, 0);
    send_frame(v, 0, N, 1'b1);
    b = 0;
    while (out_hs_count < base + 6 && b < 200) begin
      @(negedge clk);
      b++;
    end
    stall_req = 5;
    wait_idle(200);

    // Random gaps and random backpressure, including a frame with duplicates.
    ordy_random = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_frame(v, (f == 1) ? 7 : 0);
      send_frame(v, 2, N, 1'b1);
      wait_idle(400);
    end
    ordy_random = 1'b0;

    // core_y_valid held high permanently.
    core_mode = CORE_ALWAYS;
    rand_frame(v, 0);
    send_frame(v, 2, N, 1'b1);
    wait_idle(200);
    core_mode = CORE_DELAY3;

    // Core never answers: timeout, back to IDLE, sticky err.
    core_mode = CORE_NEVER;
    rand_frame(v, 0);
    send_frame(v, 0, N, 1'b0);
    b = 0;
    while (!err && b < 60) begin
      @(negedge clk);
      b++;
    end
    check("timeout_err_set", 64'(err), 64'(1));
    check("timeout_in_ready", 64'(in_ready), 64'(1));
    check("timeout_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    core_mode = CORE_DELAY3;
    rand_frame(v, 0);
    send_frame(v, 0, N, 1'b1);
    wait_idle(200);
    check("err_sticky", 64'(err), 64'(1));

    // Asynchronous reset during load beat 7, then a clean frame.
    rand_frame(v, 0);
    send_frame(v, 0, 7, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midframe_release_in_ready", 64'(in_ready), 64'(1));
    rand_frame(v, 0);
    send_frame(v, 0, N, 1'b1);
    wait_idle(200);
    check("err_after_reset", 64'(err), 64'(0));
    check("frames_pending", 64'(exp_frames.size()), 64'(0));
    check("outputs_pending", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
